// File: rtl/fp_accum_seq.sv
// fp_accum_seq
// ----------------------------------------------------------------------------
// Reduces a frame of N streamed IEEE-754 operands to one sum. The block uses an
// external pipelined FP adder and feeds each adder result back as the next left
// operand. Zero operands are absorbed locally because the adder has no zero
// special case. They either leave the accumulator unchanged or are replaced by
// the first non-zero operand. The frame sum is presented with a one-cycle
// out_valid pulse, and out_data holds that value until the next result.
//
// Optional feature: define FP_ACC_OVF_EN to build the sticky overflow detector.
// With the macro undefined, ovf is tied low and no detection logic exists.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle frame start pulse, sampled only in IDLE
//   frame_len  in   operand count N, latched on start
//   in_data    in   operand
//   in_valid   in   operand present
//   in_ready   out  operand accepted when in_valid && in_ready
//   add_in1    out  adder operand A (accumulator)
//   add_in2    out  adder operand B (latched operand)
//   add_start  out  one-cycle adder start pulse
//   add_busy   in   adder busy; no start is issued while high
//   add_valid  in   adder result-valid pulse
//   add_out    in   adder result
//   busy       out  frame in progress
//   out_valid  out  one-cycle result pulse
//   out_data   out  frame sum, held until the next result
//   ovf        out  sticky overflow flag
// ----------------------------------------------------------------------------
module fp_accum_seq #(
  parameter int exponent = 8,
  parameter int mantissa = 23,
  parameter int LEN_W    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_W-1:0]               frame_len,
  input  logic [exponent+mantissa:0]     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [exponent+mantissa:0]     add_in1,
  output logic [exponent+mantissa:0]     add_in2,
  output logic                           add_start,
  input  logic                           add_busy,
  input  logic                           add_valid,
  input  logic [exponent+mantissa:0]     add_out,
  output logic                           busy,
  output logic                           out_valid,
  output logic [exponent+mantissa:0]     out_data,
  output logic                           ovf
);

  localparam int W = exponent + mantissa + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OP  = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ADD = 3'd3,
    DONE     = 3'd4
  } state_t;

  // The sign bit is ignored, so +0 and -0 are both treated as zero.
  function automatic logic is_zero(input logic [W-1:0] v);
    return (v[W-2:0] == '0);
  endfunction

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     op_reg_q, op_reg_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  // These outputs decode directly from the state register.
  assign in_ready  = (state_q == WAIT_OP);
  assign busy      = (state_q != IDLE);
  assign add_start = (state_q == ISSUE) && !add_busy;
  assign add_in1   = acc_q;
  assign add_in2   = op_reg_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state and datapath update for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_reg_d    = op_reg_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (frame_len != '0) begin
            remaining_d = frame_len;
            state_d     = WAIT_OP;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_OP: begin
        if (in_valid) begin
          remaining_d = remaining_q - LEN_ONE;
          if (!is_zero(in_data) && !is_zero(acc_q)) begin
            op_reg_d = in_data;
            state_d  = ISSUE;
          end else begin
            // A zero operand is dropped. Otherwise, a zero accumulator takes
            // the operand as-is. Neither case needs the adder.
            if (!is_zero(in_data)) begin
              acc_d = in_data;
            end else begin
              acc_d = acc_q;
            end
            if (remaining_q == LEN_ONE) begin
              state_d = DONE;
            end else begin
              state_d = WAIT_OP;
            end
          end
        end else begin
          state_d = WAIT_OP;
        end
      end
      ISSUE: begin
        if (!add_busy) begin
          state_d = WAIT_ADD;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_ADD: begin
        if (add_valid) begin
          acc_d = add_out;
          if (remaining_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_OP;
          end
        end else begin
          state_d = WAIT_ADD;
        end
      end
      DONE: begin
        out_data_d  = acc_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_reg_q    <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_reg_q    <= op_reg_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FP_ACC_OVF_EN
  // An exponent field of all ones means infinity or NaN.
  function automatic logic exp_all_ones(input logic [W-1:0] v);
    return &v[W-2:mantissa];
  endfunction

  logic ovf_q, ovf_d;

  // Sticky overflow: cleared by an accepted start, and set by an accepted
  // operand or an accepted adder result whose exponent field is all ones.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == IDLE) && start) begin
      ovf_d = 1'b0;
    end else if ((state_q == WAIT_OP) && in_valid && exp_all_ones(in_data)) begin
      ovf_d = 1'b1;
    end else if ((state_q == WAIT_ADD) && add_valid && exp_all_ones(add_out)) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq. A 3-stage pipelined adder model sits
// behind the DUT. Expected sums are computed by plain fixed-point arithmetic
// (units of 1/256) over the operand list.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  frame_len;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] add_in1, add_in2;
  logic        add_start;
  logic        add_busy;
  logic        add_valid;
  logic [31:0] add_out;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_data;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] ops [0:15];

  always #5 clk = ~clk;

  fp_accum_seq #(.exponent(8), .mantissa(23), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_busy(add_busy), .add_valid(add_valid), .add_out(add_out),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .ovf(ovf)
  );

  // Float bits -> value scaled by 256 (exact for the operands used here).
  function automatic longint dec(input logic [31:0] b);
    int e;
    longint m, v;
    e = int'(b[30:23]);
    if (e == 0) return 64'sd0;
    m = longint'({1'b1, b[22:0]});
    if (e >= 142) v = m <<< (e - 142);
    else          v = m >>> (142 - e);
    return b[31] ? -v : v;
  endfunction

  // Value scaled by 256 -> float bits (+0 for zero).
  function automatic logic [31:0] enc(input longint v);
    longint m;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0000_0000;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 40; i++) if (m[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p - 8);
    if (p <= 23) r[22:0] = 23'(m << (23 - p));
    else         r[22:0] = 23'(m >> (p - 23));
    return r;
  endfunction

  // Adder behaviour: huge exponents saturate to +inf, otherwise exact sum.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] >= 8'hFE || b[30:23] >= 8'hFE) return 32'h7F80_0000;
    return enc(dec(a) + dec(b));
  endfunction

  // Adder model: 3-cycle latency, busy while in flight or randomly stalled.
  logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, stall = 1'b0;
  logic [31:0] r1 = 32'h0, r2 = 32'h0, r3 = 32'h0;
  logic stall_en;
  always @(posedge clk) begin
    p1 <= add_start; r1 <= fadd(add_in1, add_in2);
    p2 <= p1;        r2 <= r1;
    p3 <= p2;        r3 <= r2;
    stall <= stall_en && ($urandom_range(0, 3) == 0);
  end
  assign add_valid = p3;
  assign add_out   = r3;
  assign add_busy  = p1 | p2 | p3 | stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Runs one frame of n operands from ops[]. When hold=1, in_valid stays high
  // whenever operands remain; otherwise it is random.
  task automatic run_frame(input int n, input bit hold, input bit use_ovr,
                           input logic [31:0] ovr_data, input int ovr_adds);
    int idx = 0, adds = 0, accepts = 0, busy_cyc = 0, last_ev = 0;
    int ov_cyc = -1, ov_cnt = 0, exp_adds = 0;
    bit pend = 0;
    longint sum = 0;
    logic [31:0] exp_data;
    // Reference: zeros are skipped, a zero running sum takes the operand
    // directly, and every other non-zero operand costs one add.
    for (int i = 0; i < n; i++) begin
      if (!use_ovr && ops[i][30:0] != 31'h0) begin
        if (sum != 0) exp_adds++;
        sum = sum + dec(ops[i]);
      end
    end
    exp_data = use_ovr ? ovr_data : enc(sum);
    if (use_ovr) exp_adds = ovr_adds;

    @(negedge clk);
    start = 1'b1; frame_len = 8'(n);
    in_valid = hold && (n > 0); in_data = ops[0];
    #1;
    chk("ready_low_in_idle", {31'h0, in_ready}, 32'h0);
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = (idx < n) && (hold || $urandom_range(0, 3) != 0);
      in_data  = (idx < n) ? ops[idx] : $urandom();
      #1;
      if (busy) busy_cyc++;
      if (add_start) begin
        adds++;
        chk("no_start_while_busy", {31'h0, add_busy}, 32'h0);
        pend = 1'b1;
      end else if (pend) begin
        chk("ready_low_during_add", {31'h0, in_ready}, 32'h0);
        if (add_valid) pend = 1'b0;
      end
      if (in_valid && in_ready) begin
        idx++; accepts++; last_ev = cyc;
      end
      if (out_valid) begin
        ov_cnt++;
        if (ov_cyc < 0) begin
          ov_cyc = cyc;
          chk("sum", out_data, exp_data);
        end
      end
      if (ov_cyc >= 0 && cyc >= ov_cyc + 2) break;
    end
    chk("out_valid_pulses", ov_cnt, 1);
    chk("accepts", accepts, n);
    chk("add_starts", adds, exp_adds);
    chk("busy_after", {31'h0, busy}, 32'h0);
    chk("out_data_held", out_data, exp_data);
    // Without adds, out_valid comes two cycles after the last accept or start.
    if (exp_adds == 0 && ov_cyc >= 0) chk("no_add_latency", ov_cyc - last_ev, 2);
    if (n == 0) chk("busy_cycles_len0", busy_cyc, 1);
  endtask

  initial begin
    int idx;
    bit got_start, saw_av, saw_ov, saw_busy;
    int n;
    rst = 1'b1; start = 1'b0; frame_len = 8'h0;
    in_valid = 1'b0; in_data = 32'h0; stall_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
    chk("rst_add_start", {31'h0, add_start}, 32'h0);
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_ovf",       {31'h0, ovf},       32'h0);
    chk("rst_out_data",  out_data,           32'h0);
    @(negedge clk); rst = 1'b0;

    // Directed frames.
    ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000; ops[2] = 32'h3F00_0000;
    run_frame(3, 1'b0, 1'b0, 32'h0, 0);
    ops[0] = 32'h0000_0000; ops[1] = 32'h4040_0000;
    run_frame(2, 1'b0, 1'b0, 32'h0, 0);
    run_frame(0, 1'b0, 1'b0, 32'h0, 0);
    ops[0] = 32'h3FC0_0000; ops[1] = 32'h3FC0_0000;
    run_frame(2, 1'b1, 1'b0, 32'h0, 0);

    // Reset while the adder is in flight; its late add_valid must be ignored.
    ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000;
    @(negedge clk);
    start = 1'b1; frame_len = 8'd2; in_valid = 1'b0;
    idx = 0; got_start = 1'b0;
    for (int c = 0; c < 50 && !got_start; c++) begin
      @(negedge clk);
      start = 1'b0; in_valid = (idx < 2); in_data = ops[idx & 1];
      #1;
      if (in_valid && in_ready) idx++;
      if (add_start) got_start = 1'b1;
    end
    chk("rst_test_reached_issue", {31'h0, got_start}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_busy",      {31'h0, busy},      32'h0);
    chk("midrst_in_ready",  {31'h0, in_ready},  32'h0);
    chk("midrst_add_start", {31'h0, add_start}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_out_data",  out_data,           32'h0);
    @(negedge clk); rst = 1'b0;
    saw_av = 1'b0; saw_ov = 1'b0; saw_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (add_valid) saw_av = 1'b1;
      if (out_valid) saw_ov = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    chk("late_add_valid_seen", {31'h0, saw_av},   32'h1);
    chk("late_add_valid_no_out", {31'h0, saw_ov}, 32'h0);
    chk("late_add_valid_idle", {31'h0, saw_busy}, 32'h0);
    ops[0] = 32'h3F80_0000;
    run_frame(1, 1'b0, 1'b0, 32'h0, 0);

    // Overflow frame: the adder saturates to +inf.
    ops[0] = 32'h7F00_0000; ops[1] = 32'h7F00_0000;
    run_frame(2, 1'b0, 1'b1, 32'h7F80_0000, 1);
`ifdef FP_ACC_OVF_EN
    chk("ovf_set", {31'h0, ovf}, 32'h1);
`else
    chk("ovf_off", {31'h0, ovf}, 32'h0);
`endif
    ops[0] = 32'h3F80_0000;
    run_frame(1, 1'b0, 1'b0, 32'h0, 0);
    chk("ovf_cleared", {31'h0, ovf}, 32'h0);

    // Random frames with adder stalls.
    stall_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ops[i] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0000_0000;
        end else begin
          longint v;
          v = longint'($urandom_range(1, 2000));
          ops[i] = enc(($urandom_range(0, 1) == 1) ? -v : v);
        end
      end
      run_frame(n, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
